valid_dirty_array: RTL and testbench
====================================

VALID_DIRTY_ARRAY -- requirements
Module: valid_dirty_array

Interface
REQ-001 Parameters SHALL be: NUM_SETS, default 4, number of cache sets (power of two, >=2); NUM_WAYS, default 2, number of ways; IDX_W, default clog2(NUM_SETS), index width; INIT_VALID, default 0, valid value loaded into every line at reset (0 or 1).
REQ-002 Ports SHALL be, in order: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; sampled only on rising clk edge.
REQ-004 rd_index  in  IDX_W  lookup set index.
REQ-005 valid_out  out  NUM_WAYS  valid bits of set rd_index, one per way, combinational from stored state.
REQ-006 dirty_out  out  NUM_WAYS  dirty bits of set rd_index, combinational.
REQ-007 wr_en  in  1  line fill/update request.
REQ-008 wr_index  in  IDX_W  set index for wr_en/clr_en.
REQ-009 wr_way  in  NUM_WAYS  one-hot way select for wr_en/clr_en.
REQ-010 wr_dirty  in  1  dirty value written with wr_en.
REQ-011 clr_en  in  1  single-line invalidate request.
REQ-012 inv_req  in  1  invalidate-all request.
REQ-013 inv_busy  out  1  invalidate-all sweep in progress.
REQ-014 inv_done  out  1  one-cycle pulse, sweep complete.
REQ-015 wr_ready  out  1  high when wr_en/clr_en are accepted; equals ~inv_busy.

Function
REQ-016 Storage SHALL be NUM_SETS x NUM_WAYS valid bits and the same number of dirty bits, all flops.
REQ-017 wr_en accepted (wr_ready=1) SHALL set valid=1 and dirty=wr_dirty for every line at wr_index whose wr_way bit is 1, visible on valid_out/dirty_out the cycle after the edge.
REQ-018 clr_en accepted SHALL clear valid and dirty of selected lines.
REQ-019 wr_en and clr_en both high in one cycle SHALL give clr_en priority (line invalid, clean).
REQ-020 wr_way with zero bits set SHALL change no state; multiple bits set SHALL update all selected ways.
REQ-021 wr_en/clr_en with wr_ready=0 SHALL be ignored, not queued.
REQ-022 Sweep FSM states SHALL be IDLE and SWEEP; a sweep counter of IDX_W bits.
REQ-023 IDLE with inv_req=1 SHALL go to SWEEP on next edge, counter=0, inv_busy=1 from that cycle.
REQ-024 Each SWEEP cycle SHALL clear valid and dirty of all ways of set counter, then increment counter.
REQ-025 In the SWEEP cycle with counter=NUM_SETS-1 the FSM SHALL clear that set and return to IDLE; inv_done SHALL be 1 during the first IDLE cycle after sweep, 0 otherwise.
REQ-026 Sweep SHALL take exactly NUM_SETS cycles with inv_busy=1; counter wrap to 0 SHALL not start a second pass.
REQ-027 inv_req during SWEEP SHALL be ignored; inv_req held high in the inv_done cycle SHALL start a new sweep on the next edge.
REQ-028 An accepted wr_en in the same cycle inv_req is accepted SHALL be performed; the sweep subsequently clears it.
REQ-029 valid_out/dirty_out during SWEEP SHALL reflect stored state (cleared sets read 0, uncleared sets read prior values).
REQ-030 Out-of-range or X-free behaviour: all indices are in range by construction; no further checking.

Reset
REQ-031 reset=0 at a rising edge SHALL set every valid bit to INIT_VALID, every dirty bit to 0, FSM to IDLE, counter to 0.
REQ-032 Reset values of outputs: inv_busy=0, inv_done=0, wr_ready=1, valid_out={NUM_WAYS{INIT_VALID}}, dirty_out=0.
REQ-033 reset=0 mid-sweep SHALL abort the sweep with no inv_done pulse; reset SHALL override all simultaneous wr_en/clr_en/inv_req.

Verification (NUM_SETS=4, NUM_WAYS=2, INIT_VALID=0 unless stated)
REQ-034 Reset then wr_en, wr_index=2, wr_way=2'b10, wr_dirty=1 -> next cycle rd_index=2 gives valid_out=2'b10, dirty_out=2'b10; rd_index=1 gives 2'b00.
REQ-035 Fill all 8 lines, pulse inv_req -> inv_busy high exactly 4 cycles, sets cleared in order 0..3, inv_done high 1 cycle, then all valid_out=0.
REQ-036 wr_en and clr_en same cycle, index 1, way 2'b01, line previously valid -> valid_out[0]=0, dirty_out[0]=0.
REQ-037 wr_en issued during sweep cycle 2 to set 0 -> wr_ready=0, set 0 remains invalid after inv_done.
REQ-038 reset asserted in sweep cycle 2 -> inv_busy=0 next cycle, no inv_done, all dirty=0.
REQ-039 INIT_VALID=1, reset -> valid_out=2'b11 for every rd_index, dirty_out=2'b00.

Source files
------------

// File: rtl/valid_dirty_array.sv
// Per-line valid/dirty flops for a set-associative cache, read combinationally by set index.
// Line fill/clear takes effect on the next edge; invalidate-all sweeps one set per cycle and holds off writes while busy.
module valid_dirty_array #(
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2,
    parameter int IDX_W      = $clog2(NUM_SETS),
    parameter bit INIT_VALID = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_W-1:0]    rd_index,
    output logic [NUM_WAYS-1:0] valid_out,
    output logic [NUM_WAYS-1:0] dirty_out,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_index,
    input  logic [NUM_WAYS-1:0] wr_way,
    input  logic                wr_dirty,
    input  logic                clr_en,
    input  logic                inv_req,
    output logic                inv_busy,
    output logic                inv_done,
    output logic                wr_ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

    state_e                             state_q, state_d;
    logic [IDX_W-1:0]                   cnt_q, cnt_d;
    logic                               done_q, done_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid_q, valid_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]  dirty_q, dirty_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        dirty_d = dirty_q;
        case (state_q)
            IDLE: begin
                // Invalidate wins over a simultaneous fill of the same lines.
                if (clr_en) begin
                    valid_d[wr_index] = valid_q[wr_index] & ~wr_way;
                    dirty_d[wr_index] = dirty_q[wr_index] & ~wr_way;
                end else if (wr_en) begin
                    valid_d[wr_index] = valid_q[wr_index] | wr_way;
                    dirty_d[wr_index] = (dirty_q[wr_index] & ~wr_way)
                                      | (wr_way & {NUM_WAYS{wr_dirty}});
                end
                if (inv_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                valid_d[cnt_q] = '0;
                dirty_d[cnt_q] = '0;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST_SET) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= {NUM_SETS{{NUM_WAYS{INIT_VALID}}}};
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    assign valid_out = valid_q[rd_index];
    assign dirty_out = dirty_q[rd_index];
    assign inv_busy  = (state_q == SWEEP);
    assign wr_ready  = (state_q == IDLE);
    assign inv_done  = done_q;

endmodule

// File: tb/tb_valid_dirty_array.sv
// Randomised and directed check of valid_dirty_array against a set-level behavioural model.
module tb_valid_dirty_array;
    localparam int NS = 4;
    localparam int NW = 2;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] rd_index, wr_index;
    logic [NW-1:0] wr_way;
    logic          wr_en, wr_dirty, clr_en, inv_req;
    logic [NW-1:0] valid_out, dirty_out, valid_out1, dirty_out1;
    logic          inv_busy, inv_done, wr_ready;
    logic          inv_busy1, inv_done1, wr_ready1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: per-line bits plus a queue of sets still waiting to be swept.
    bit m_valid [NS][NW];
    bit m_dirty [NS][NW];
    int sweep_q [$];
    bit m_done;

    always #5 clk = ~clk;

    valid_dirty_array #(.NUM_SETS(NS), .NUM_WAYS(NW), .INIT_VALID(1'b0)) dut (
        .clk(clk), .reset(reset), .rd_index(rd_index),
        .valid_out(valid_out), .dirty_out(dirty_out),
        .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_dirty(wr_dirty),
        .clr_en(clr_en), .inv_req(inv_req),
        .inv_busy(inv_busy), .inv_done(inv_done), .wr_ready(wr_ready)
    );

    valid_dirty_array #(.NUM_SETS(NS), .NUM_WAYS(NW), .INIT_VALID(1'b1)) dut1 (
        .clk(clk), .reset(reset), .rd_index(rd_index),
        .valid_out(valid_out1), .dirty_out(dirty_out1),
        .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_dirty(wr_dirty),
        .clr_en(clr_en), .inv_req(inv_req),
        .inv_busy(inv_busy1), .inv_done(inv_done1), .wr_ready(wr_ready1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NW-1:0] row_v(input int s);
        logic [NW-1:0] r;
        for (int w = 0; w < NW; w++) r[w] = m_valid[s][w];
        return r;
    endfunction

    function automatic logic [NW-1:0] row_d(input int s);
        logic [NW-1:0] r;
        for (int w = 0; w < NW; w++) r[w] = m_dirty[s][w];
        return r;
    endfunction

    task automatic compare();
        if (chk_en) begin
            chk("model valid_out", valid_out, row_v(int'(rd_index)));
            chk("model dirty_out", dirty_out, row_d(int'(rd_index)));
            chk("model inv_busy", inv_busy, sweep_q.size() > 0);
            chk("model wr_ready", wr_ready, sweep_q.size() == 0);
            chk("model inv_done", inv_done, m_done);
        end
    endtask

    task automatic model_edge();
        int s;
        bit nd;
        nd = 1'b0;
        if (!reset) begin
            foreach (m_valid[i, j]) begin
                m_valid[i][j] = 1'b0;
                m_dirty[i][j] = 1'b0;
            end
            sweep_q.delete();
        end else if (sweep_q.size() == 0) begin
            for (int w = 0; w < NW; w++) begin
                if (wr_way[w] && clr_en) begin
                    m_valid[wr_index][w] = 1'b0;
                    m_dirty[wr_index][w] = 1'b0;
                end else if (wr_way[w] && wr_en) begin
                    m_valid[wr_index][w] = 1'b1;
                    m_dirty[wr_index][w] = wr_dirty;
                end
            end
            if (inv_req) for (int i = 0; i < NS; i++) sweep_q.push_back(i);
        end else begin
            s = sweep_q.pop_front();
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            nd = (sweep_q.size() == 0);
        end
        m_done = nd;
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_in();
        reset = 1'b1; wr_en = 1'b0; clr_en = 1'b0; inv_req = 1'b0;
    endtask

    task automatic peek(input int idx);
        rd_index = IW'(idx);
        #1;
    endtask

    task automatic fill_all();
        for (int s = 0; s < NS; s++) begin
            wr_en = 1'b1; wr_index = IW'(s); wr_way = 2'b11; wr_dirty = 1'b1;
            step();
        end
        idle_in();
    endtask

    initial begin
        int cnt;
        m_done = 1'b0;
        reset = 1'b0; wr_en = 1'b0; clr_en = 1'b0; inv_req = 1'b0;
        wr_index = '0; wr_way = '0; wr_dirty = 1'b0; rd_index = '0;
        step();
        chk_en = 1'b1;

        // Reset state for both INIT_VALID settings.
        chk("rst inv_busy", inv_busy, 0);
        chk("rst inv_done", inv_done, 0);
        chk("rst wr_ready", wr_ready, 1);
        chk("rst1 inv_busy", inv_busy1, 0);
        chk("rst1 inv_done", inv_done1, 0);
        chk("rst1 wr_ready", wr_ready1, 1);
        for (int i = 0; i < NS; i++) begin
            peek(i);
            chk("rst valid_out", valid_out, 2'b00);
            chk("rst dirty_out", dirty_out, 2'b00);
            chk("init1 valid_out", valid_out1, 2'b11);
            chk("init1 dirty_out", dirty_out1, 2'b00);
        end

        // Single fill.
        idle_in();
        wr_en = 1'b1; wr_index = 2'd2; wr_way = 2'b10; wr_dirty = 1'b1;
        step();
        idle_in();
        peek(2);
        chk("fill valid set2", valid_out, 2'b10);
        chk("fill dirty set2", dirty_out, 2'b10);
        peek(1);
        chk("fill valid set1", valid_out, 2'b00);
        chk("fill dirty set1", dirty_out, 2'b00);

        // Full sweep: sets cleared in order, busy for exactly NS cycles.
        fill_all();
        inv_req = 1'b1;
        step();
        inv_req = 1'b0;
        cnt = 0;
        while (inv_busy && cnt < 10) begin
            peek(cnt);
            chk("sweep pre-clear", valid_out, 2'b11);
            step();
            peek(cnt);
            chk("sweep post-clear", valid_out, 2'b00);
            cnt++;
        end
        chk("sweep busy cycles", cnt, 4);
        chk("sweep inv_done pulse", inv_done, 1);
        step();
        chk("sweep inv_done drop", inv_done, 0);
        for (int i = 0; i < NS; i++) begin
            peek(i);
            chk("post-sweep valid", valid_out, 2'b00);
        end

        // Clear beats fill on the same line.
        wr_en = 1'b1; wr_index = 2'd1; wr_way = 2'b01; wr_dirty = 1'b1;
        step();
        clr_en = 1'b1;
        step();
        idle_in();
        peek(1);
        chk("clr prio valid[0]", valid_out[0], 0);
        chk("clr prio dirty[0]", dirty_out[0], 0);

        // Write during sweep is dropped.
        fill_all();
        inv_req = 1'b1;
        step();
        inv_req = 1'b0;
        step();
        wr_en = 1'b1; wr_index = 2'd0; wr_way = 2'b11; wr_dirty = 1'b1;
        chk("sweep wr_ready", wr_ready, 0);
        step();
        idle_in();
        cnt = 0;
        while (inv_busy && cnt < 10) begin
            step();
            cnt++;
        end
        chk("dropped-wr inv_done", inv_done, 1);
        peek(0);
        chk("dropped-wr set0 valid", valid_out, 2'b00);

        // Reset mid-sweep aborts without a done pulse.
        fill_all();
        inv_req = 1'b1;
        step();
        inv_req = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort inv_busy", inv_busy, 0);
        chk("abort inv_done", inv_done, 0);
        for (int i = 0; i < NS; i++) begin
            peek(i);
            chk("abort dirty", dirty_out, 2'b00);
        end
        step();
        chk("abort no done", inv_done, 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) != 0);
            wr_en    = ($urandom_range(0, 1) == 1);
            clr_en   = ($urandom_range(0, 4) == 0);
            inv_req  = ($urandom_range(0, 24) == 0);
            wr_index = IW'($urandom_range(0, NS - 1));
            wr_way   = NW'($urandom_range(0, 3));
            wr_dirty = ($urandom_range(0, 1) == 1);
            rd_index = IW'($urandom_range(0, NS - 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
